// File: rtl/ps2_ascii_fifo.sv
// PS/2 set-2 scan-code decoder: prefix FSM, Shift/CapsLock tracking, ASCII translation
// and a show-ahead character FIFO drained by the VGA text writer.
module ps2_ascii_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic       FPGAClk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  input  logic       rd_en,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift,
  output logic       caps
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  logic [1:0]      state;
  logic            dec_valid;
  logic [7:0]      dec_char;
  logic [8:0]      xlat;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            empty;
  logic            pop;
  logic            push;

  // Returns {mapped, character}; letters are case-adjusted by shift XOR caps,
  // digits only by shift.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic sh, input logic cp);
    logic [7:0] ch;
    logic       letter;
    logic       mapped;
    ch     = 8'h00;
    letter = 1'b0;
    mapped = 1'b1;
    case (code)
      8'h1C: begin ch = 8'h61; letter = 1'b1; end
      8'h32: begin ch = 8'h62; letter = 1'b1; end
      8'h21: begin ch = 8'h63; letter = 1'b1; end
      8'h23: begin ch = 8'h64; letter = 1'b1; end
      8'h24: begin ch = 8'h65; letter = 1'b1; end
      8'h2B: begin ch = 8'h66; letter = 1'b1; end
      8'h34: begin ch = 8'h67; letter = 1'b1; end
      8'h33: begin ch = 8'h68; letter = 1'b1; end
      8'h43: begin ch = 8'h69; letter = 1'b1; end
      8'h3B: begin ch = 8'h6A; letter = 1'b1; end
      8'h42: begin ch = 8'h6B; letter = 1'b1; end
      8'h4B: begin ch = 8'h6C; letter = 1'b1; end
      8'h3A: begin ch = 8'h6D; letter = 1'b1; end
      8'h31: begin ch = 8'h6E; letter = 1'b1; end
      8'h44: begin ch = 8'h6F; letter = 1'b1; end
      8'h4D: begin ch = 8'h70; letter = 1'b1; end
      8'h15: begin ch = 8'h71; letter = 1'b1; end
      8'h2D: begin ch = 8'h72; letter = 1'b1; end
      8'h1B: begin ch = 8'h73; letter = 1'b1; end
      8'h2C: begin ch = 8'h74; letter = 1'b1; end
      8'h3C: begin ch = 8'h75; letter = 1'b1; end
      8'h2A: begin ch = 8'h76; letter = 1'b1; end
      8'h1D: begin ch = 8'h77; letter = 1'b1; end
      8'h22: begin ch = 8'h78; letter = 1'b1; end
      8'h35: begin ch = 8'h79; letter = 1'b1; end
      8'h1A: begin ch = 8'h7A; letter = 1'b1; end
      8'h16: ch = sh ? 8'h21 : 8'h31;
      8'h1E: ch = sh ? 8'h40 : 8'h32;
      8'h26: ch = sh ? 8'h23 : 8'h33;
      8'h25: ch = sh ? 8'h24 : 8'h34;
      8'h2E: ch = sh ? 8'h25 : 8'h35;
      8'h36: ch = sh ? 8'h5E : 8'h36;
      8'h3D: ch = sh ? 8'h26 : 8'h37;
      8'h3E: ch = sh ? 8'h2A : 8'h38;
      8'h46: ch = sh ? 8'h28 : 8'h39;
      8'h45: ch = sh ? 8'h29 : 8'h30;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: mapped = 1'b0;
    endcase
    if (letter && (sh ^ cp)) ch = ch - 8'h20;
    return {mapped, ch};
  endfunction

  always_comb begin
    xlat = translate(code_in, shift, caps);
  end

  // Prefix FSM and decode register; modifier keys update state but never push.
  always_ff @(posedge FPGAClk) begin
    if (!rst) begin
      state     <= IDLE;
      shift     <= 1'b0;
      caps      <= 1'b0;
      dec_valid <= 1'b0;
      dec_char  <= 8'h00;
    end else begin
      dec_valid <= 1'b0;
      if (code_valid) begin
        case (state)
          IDLE: begin
            if (code_in == 8'hF0)                         state <= BRK;
            else if (code_in == 8'hE0)                    state <= EXT;
            else if (code_in == 8'h12 || code_in == 8'h59) shift <= 1'b1;
            else if (code_in == 8'h58)                    caps  <= ~caps;
            else begin
              dec_valid <= xlat[8];
              dec_char  <= xlat[7:0];
            end
          end
          BRK: begin
            if (code_in == 8'h12 || code_in == 8'h59) shift <= 1'b0;
            state <= IDLE;
          end
          EXT:     state <= (code_in == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty       = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop         = rd_en && !empty;
  assign push        = dec_valid && (!fifo_full || pop);
  assign ascii_valid = !empty;
  assign ascii_out   = empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

  // A push into a full FIFO survives only when a pop frees a slot on the same edge.
  always_ff @(posedge FPGAClk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (dec_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge FPGAClk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= dec_char;
  end

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Directed bench for ps2_ascii_fifo: scan-code sequences with hand-computed ASCII results.
module tb_ps2_ascii_fifo;

  logic       FPGAClk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       fifo_full;
  logic       overflow;
  logic       shift;
  logic       caps;

  int errors = 0;
  int checks = 0;

  ps2_ascii_fifo #(.ADDR_W(4)) dut (
    .FPGAClk(FPGAClk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .rd_en(rd_en), .ascii_out(ascii_out), .ascii_valid(ascii_valid),
    .fifo_full(fifo_full), .overflow(overflow), .shift(shift), .caps(caps)
  );

  always #5 FPGAClk = ~FPGAClk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle code_valid pulse; returns on the negedge after the sampling edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge FPGAClk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge FPGAClk);
    code_valid = 1'b0;
  endtask

  task automatic popChar();
    @(negedge FPGAClk);
    rd_en = 1'b1;
    @(negedge FPGAClk);
    rd_en = 1'b0;
  endtask

  task automatic doReset();
    @(negedge FPGAClk);
    rst = 1'b0;
    @(negedge FPGAClk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] first_ch;
    logic [7:0] last_ch;

    repeat (2) @(negedge FPGAClk);
    rst = 1'b1;
    checkOutput("reset_valid", ascii_valid, 0);
    checkOutput("reset_out", ascii_out, 8'h00);
    checkOutput("reset_full", fifo_full, 0);
    checkOutput("reset_ovf", overflow, 0);
    checkOutput("reset_shift", shift, 0);
    checkOutput("reset_caps", caps, 0);

    // 1: single make code, two-cycle latency
    applyStimulus(8'h1C);
    checkOutput("lat_not_yet", ascii_valid, 0);
    @(negedge FPGAClk);
    checkOutput("t1_valid", ascii_valid, 1);
    checkOutput("t1_char", ascii_out, 8'h61);
    popChar();
    checkOutput("t1_popped", ascii_valid, 0);

    // 2: shift make/break around letters
    applyStimulus(8'h12);
    checkOutput("t2_shift_on", shift, 1);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkOutput("t2_shift_off", shift, 0);
    applyStimulus(8'h1C);
    @(negedge FPGAClk);
    checkOutput("t2_head_A", ascii_out, 8'h41);
    popChar();
    checkOutput("t2_head_a", ascii_out, 8'h61);
    popChar();
    checkOutput("t2_empty", ascii_valid, 0);

    // 3: caps lock toggles on make only; caps does not affect digits
    applyStimulus(8'h58);
    checkOutput("t3_caps_on", caps, 1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    checkOutput("t3_caps_hold", caps, 1);
    applyStimulus(8'h32);
    applyStimulus(8'h16);
    applyStimulus(8'h12);
    applyStimulus(8'h16);
    applyStimulus(8'h1C);
    applyStimulus(8'h29);
    @(negedge FPGAClk);
    checkOutput("t3_B", ascii_out, 8'h42);
    popChar();
    checkOutput("t3_1", ascii_out, 8'h31);
    popChar();
    checkOutput("t3_bang", ascii_out, 8'h21);
    popChar();
    checkOutput("t3_shift_caps_a", ascii_out, 8'h61);
    popChar();
    checkOutput("t3_space", ascii_out, 8'h20);
    popChar();
    checkOutput("t3_empty", ascii_valid, 0);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    applyStimulus(8'h58);
    checkOutput("t3_shift_rel", shift, 0);
    checkOutput("t3_caps_off", caps, 0);

    // 4: extended sequences discarded, FSM back in IDLE
    applyStimulus(8'hE0);
    applyStimulus(8'h5A);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h5A);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    repeat (2) @(negedge FPGAClk);
    checkOutput("t4_nothing", ascii_valid, 0);
    applyStimulus(8'h5A);
    @(negedge FPGAClk);
    checkOutput("t4_enter", ascii_out, 8'h0D);
    applyStimulus(8'h66);
    popChar();
    checkOutput("t4_bksp", ascii_out, 8'h08);
    popChar();
    checkOutput("t4_empty", ascii_valid, 0);

    // 5: fill to 16 with back-to-back typematic codes, then overflow
    @(negedge FPGAClk);
    code_in    = 8'h1C;
    code_valid = 1'b1;
    repeat (16) @(negedge FPGAClk);
    code_valid = 1'b0;
    repeat (2) @(negedge FPGAClk);
    checkOutput("t5_full", fifo_full, 1);
    checkOutput("t5_no_ovf_yet", overflow, 0);
    applyStimulus(8'h1C);
    @(negedge FPGAClk);
    checkOutput("t5_ovf", overflow, 1);
    checkOutput("t5_still_full", fifo_full, 1);
    // push 'b' on the same edge as a pop while full
    @(negedge FPGAClk);
    code_in    = 8'h32;
    code_valid = 1'b1;
    @(negedge FPGAClk);
    code_valid = 1'b0;
    rd_en      = 1'b1;
    @(negedge FPGAClk);
    rd_en = 1'b0;
    checkOutput("t5_full_after_swap", fifo_full, 1);
    checkOutput("t5_ovf_sticky", overflow, 1);
    n        = 0;
    first_ch = ascii_out;
    last_ch  = 8'h00;
    for (int i = 0; i < 20 && ascii_valid; i++) begin
      last_ch = ascii_out;
      n++;
      popChar();
    end
    checkOutput("t5_count", n, 16);
    checkOutput("t5_first", first_ch, 8'h61);
    checkOutput("t5_last", last_ch, 8'h62);
    checkOutput("t5_ovf_after_drain", overflow, 1);

    // 6: reset mid-prefix discards the pending break and clears overflow
    applyStimulus(8'h12);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    doReset();
    checkOutput("t6_empty", ascii_valid, 0);
    checkOutput("t6_shift", shift, 0);
    checkOutput("t6_caps", caps, 0);
    checkOutput("t6_ovf", overflow, 0);
    applyStimulus(8'h1C);
    @(negedge FPGAClk);
    checkOutput("t6_valid", ascii_valid, 1);
    checkOutput("t6_char", ascii_out, 8'h61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
